// File: rtl/rnn_mem_pkg.sv
// Shared definitions for the RNN parameter/result memory port and its arbiters.
package rnn_mem_pkg;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 20;
   localparam int SEL_W  = 3;

   // msel region map
   localparam logic [SEL_W-1:0] MSEL_W_IH = 3'b000;
   localparam logic [SEL_W-1:0] MSEL_B_IH = 3'b001;
   localparam logic [SEL_W-1:0] MSEL_W_HH = 3'b010;
   localparam logic [SEL_W-1:0] MSEL_B_HH = 3'b011;
   localparam logic [SEL_W-1:0] MSEL_TIME = 3'b100;
   localparam logic [SEL_W-1:0] MSEL_HOUT = 3'b101;

   // Read-return tag; owner is sized for the largest supported requester count (8)
   typedef struct packed {
      logic       valid;
      logic [2:0] owner;
   } rd_tag_t;

   // Hidden output is the only writable region
   function automatic logic is_write(input logic [SEL_W-1:0] sel);
      return (sel == MSEL_HOUT);
   endfunction

endpackage

// File: rtl/rnn_mem_arbiter_rr_pick.sv
// Rotating-priority picker: first requesting index at or after ptr, wrapping.
module rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_onehot,
   output logic [IDX_W-1:0] o_index
);

   logic w_found;
   int   w_j;

   // Scan N slots starting at ptr; the first active request wins
   always_comb begin
      o_onehot = '0;
      o_index  = '0;
      w_found  = 1'b0;
      w_j      = 0;
      for (int k = 0; k < N; k++) begin
         w_j = int'(i_ptr) + k;
         if (w_j >= N) w_j = w_j - N;
         if (!w_found && i_req[w_j]) begin
            w_found       = 1'b1;
            o_onehot[w_j] = 1'b1;
            o_index       = IDX_W'(w_j);
         end
      end
   end

endmodule

// File: rtl/rnn_mem_arbiter.sv
// Round-robin arbiter with burst locking for the shared RNN memory port.
// Winning command is registered onto the bus; read data returns 2 cycles later.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_OPEN    | round robin among all requesters from rr_ptr
//   ST_LOCKED  | only r_owner may be granted; idle cycles count toward release
module rnn_mem_arbiter
   import rnn_mem_pkg::*;
#(
   parameter int NREQ         = 2,
   parameter int LOCK_TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        i_req,
   input  logic [NREQ-1:0]        i_lock,
   input  logic [NREQ*SEL_W-1:0]  i_sel,
   input  logic [NREQ*ADDR_W-1:0] i_addr,
   input  logic [NREQ*DATA_W-1:0] i_wdata,
   output logic [NREQ-1:0]        o_gnt,
   output logic [NREQ-1:0]        o_rvalid,
   output logic [DATA_W-1:0]      o_rdata,
   output logic                   o_mce,
   output logic [SEL_W-1:0]       o_msel,
   output logic [ADDR_W-1:0]      o_maddr,
   output logic [DATA_W-1:0]      o_mdata_w,
   input  logic [DATA_W-1:0]      i_mdata_r
);

   localparam int IDX_W = $clog2(NREQ);

   localparam logic [0:0] ST_OPEN   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]        r_state;
   logic [IDX_W-1:0]  r_owner;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic [3:0]        r_lock_cnt;

   logic [NREQ-1:0]   w_req_elig;
   logic [NREQ-1:0]   w_pick;
   logic [IDX_W-1:0]  w_win;
   logic              w_hs;
   logic              w_win_lock;
   logic              w_owner_idle;
   logic [SEL_W-1:0]  w_sel;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;

   logic              r_mce;
   logic [SEL_W-1:0]  r_msel;
   logic [ADDR_W-1:0] r_maddr;
   logic [DATA_W-1:0] r_mdata_w;
   rd_tag_t           r_tag;
   logic [NREQ-1:0]   r_rvalid;

   function automatic logic [IDX_W-1:0] inc_ptr(input logic [IDX_W-1:0] p);
      return (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
   endfunction

   // While locked, mask every request except the owner's
   always_comb begin
      w_req_elig = i_req;
      if (r_state == ST_LOCKED) w_req_elig = i_req & (NREQ'(1) << r_owner);
   end

   rr_pick #(.N(NREQ), .IDX_W(IDX_W)) u_pick (
      .i_req    (w_req_elig),
      .i_ptr    (r_rr_ptr),
      .o_onehot (w_pick),
      .o_index  (w_win)
   );

   assign o_gnt        = reset ? '0 : w_pick;
   assign w_hs         = |o_gnt;
   assign w_win_lock   = i_lock[w_win];
   assign w_sel        = i_sel[w_win*SEL_W +: SEL_W];
   assign w_addr       = i_addr[w_win*ADDR_W +: ADDR_W];
   assign w_wdata      = i_wdata[w_win*DATA_W +: DATA_W];
   assign w_owner_idle = (r_state == ST_LOCKED) && !i_req[r_owner];

   // Ownership, rotation pointer and idle-release down-counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_OPEN;
         r_owner    <= '0;
         r_rr_ptr   <= '0;
         r_lock_cnt <= '0;
      end else if (w_hs) begin
         if (w_win_lock) begin
            r_state    <= ST_LOCKED;
            r_owner    <= w_win;
            r_lock_cnt <= 4'(LOCK_TIMEOUT);
         end else begin
            r_state  <= ST_OPEN;
            r_rr_ptr <= inc_ptr(w_win);
         end
      end else if (w_owner_idle) begin
         if (r_lock_cnt <= 4'd1) begin
            r_state  <= ST_OPEN;
            r_rr_ptr <= inc_ptr(r_owner);
         end else begin
            r_lock_cnt <= r_lock_cnt - 4'd1;
         end
      end
   end

   // Register the winning command onto the memory bus; reads leave mdata_w alone
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mce     <= 1'b0;
         r_msel    <= MSEL_TIME;
         r_maddr   <= '0;
         r_mdata_w <= '0;
      end else begin
         r_mce <= w_hs;
         if (w_hs) begin
            r_msel  <= w_sel;
            r_maddr <= w_addr;
            if (is_write(w_sel)) r_mdata_w <= w_wdata;
         end
      end
   end

   // Two-stage read tag: issue edge captures the owner, next edge raises rvalid
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tag    <= '0;
         r_rvalid <= '0;
      end else begin
         r_tag.valid <= w_hs && !is_write(w_sel);
         r_tag.owner <= 3'(w_win);
         r_rvalid    <= r_tag.valid ? (NREQ'(1) << r_tag.owner) : '0;
      end
   end

   assign o_mce     = r_mce;
   assign o_msel    = r_msel;
   assign o_maddr   = r_maddr;
   assign o_mdata_w = r_mdata_w;
   assign o_rvalid  = r_rvalid;
   assign o_rdata   = i_mdata_r;

endmodule

// File: tb/tb_rnn_mem_arbiter.sv
// Directed bench for rnn_mem_arbiter with a small synchronous memory model.
module tb_rnn_mem_arbiter;

   logic        clk;
   logic        reset;
   logic [1:0]  req;
   logic [1:0]  lock;
   logic [5:0]  sel;
   logic [33:0] addr;
   logic [39:0] wdata;
   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [19:0] rdata;
   logic        mce;
   logic [2:0]  msel;
   logic [16:0] maddr;
   logic [19:0] mdata_w;
   logic [19:0] mdata_r;

   int errors = 0;
   int checks = 0;

   logic [19:0]  mem [0:255];
   logic [255:0] wr_flag;

   rnn_mem_arbiter #(.NREQ(2), .LOCK_TIMEOUT(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_req     (req),
      .i_lock    (lock),
      .i_sel     (sel),
      .i_addr    (addr),
      .i_wdata   (wdata),
      .o_gnt     (gnt),
      .o_rvalid  (rvalid),
      .o_rdata   (rdata),
      .o_mce     (mce),
      .o_msel    (msel),
      .o_maddr   (maddr),
      .o_mdata_w (mdata_w),
      .i_mdata_r (mdata_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: unwritten words read back as 0x5A0<addr[7:0]>; data one cycle after sampling
   always @(posedge clk) begin
      if (reset) begin
         wr_flag <= '0;
      end else if (mce) begin
         if (msel == 3'b101) begin
            mem[maddr[7:0]]     <= mdata_w;
            wr_flag[maddr[7:0]] <= 1'b1;
         end else begin
            mdata_r <= wr_flag[maddr[7:0]] ? mem[maddr[7:0]] : {12'h5A0, maddr[7:0]};
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input int r, input logic [2:0] s, input logic [16:0] a,
                          input logic [19:0] d);
      sel[r*3 +: 3]     = s;
      addr[r*17 +: 17]  = a;
      wdata[r*20 +: 20] = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      req   = 2'b11;
      lock  = 2'b00;
      sel   = '0;
      addr  = '0;
      wdata = '0;
      set_cmd(0, 3'b000, 17'h00010, 20'h0);
      set_cmd(1, 3'b000, 17'h00020, 20'h0);

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_mce", mce, 1'b0);
      chk("rst_msel", msel, 3'b100);
      chk("rst_rvalid", rvalid, 2'b00);
      reset = 1'b0;
      #1;
      chk("rst_first_gnt", gnt, 2'b01);

      // round robin, continuous reads
      @(negedge clk); #1;
      chk("rr_gnt1", gnt, 2'b10);
      chk("rr_mce1", mce, 1'b1);
      chk("rr_maddr1", maddr, 17'h00010);
      chk("rr_rvalid1", rvalid, 2'b00);
      @(negedge clk); #1;
      chk("rr_gnt2", gnt, 2'b01);
      chk("rr_rvalid2", rvalid, 2'b01);
      chk("rr_rdata2", rdata, 20'h5A010);
      chk("rr_maddr2", maddr, 17'h00020);
      @(negedge clk); #1;
      chk("rr_gnt3", gnt, 2'b10);
      chk("rr_rvalid3", rvalid, 2'b10);
      chk("rr_rdata3", rdata, 20'h5A020);
      req = 2'b00;
      @(negedge clk); #1;
      chk("rr_rvalid4", rvalid, 2'b01);
      chk("rr_rdata4", rdata, 20'h5A010);
      chk("rr_mce_idle", mce, 1'b0);
      @(negedge clk); #1;
      chk("rr_rvalid5", rvalid, 2'b00);
      req = 2'b10;
      #1;
      chk("ptr_r1_gnt", gnt, 2'b10);

      // lock burst: r0 lock=1,1,1,0 while r1 waits
      @(negedge clk); #1;
      req  = 2'b11;
      lock = 2'b01;
      #1;
      chk("lock_gnt1", gnt, 2'b01);
      @(negedge clk); #1;
      chk("lock_gnt2", gnt, 2'b01);
      @(negedge clk); #1;
      chk("lock_gnt3", gnt, 2'b01);
      @(negedge clk); #1;
      lock = 2'b00;
      #1;
      chk("lock_gnt4", gnt, 2'b01);
      @(negedge clk); #1;
      chk("lock_release_gnt", gnt, 2'b10);

      // lock timeout
      req  = 2'b01;
      lock = 2'b01;
      #1;
      chk("to_lock_gnt", gnt, 2'b01);
      @(negedge clk); #1;
      req  = 2'b10;
      lock = 2'b00;
      for (int i = 0; i < 15; i++) begin
         #1;
         chk($sformatf("to_idle%0d", i), gnt, 2'b00);
         @(negedge clk);
      end
      #1;
      chk("to_release_gnt", gnt, 2'b10);

      // write then read back
      set_cmd(1, 3'b101, 17'h00043, 20'h0ABCD);
      @(negedge clk); #1;
      chk("wr_mce", mce, 1'b1);
      chk("wr_msel", msel, 3'b101);
      chk("wr_maddr", maddr, 17'h00043);
      chk("wr_mdata_w", mdata_w, 20'h0ABCD);
      set_cmd(1, 3'b000, 17'h00043, 20'h00000);
      #1;
      chk("rd_gnt", gnt, 2'b10);
      @(negedge clk); #1;
      req = 2'b00;
      chk("wr_no_rvalid", rvalid, 2'b00);
      chk("rd_mdata_w_hold", mdata_w, 20'h0ABCD);
      chk("rd_msel", msel, 3'b000);
      @(negedge clk); #1;
      chk("rd_rvalid", rvalid, 2'b10);
      chk("rd_rdata", rdata, 20'h0ABCD);
      @(negedge clk); #1;
      chk("rd_rvalid_off", rvalid, 2'b00);

      // reset mid-operation
      set_cmd(0, 3'b000, 17'h00010, 20'h0);
      req = 2'b01;
      #1;
      chk("mid_gnt", gnt, 2'b01);
      @(negedge clk); #1;
      chk("mid_mce", mce, 1'b1);
      req   = 2'b00;
      reset = 1'b1;
      @(negedge clk); #1;
      chk("mid_rvalid1", rvalid, 2'b00);
      chk("mid_mce_rst", mce, 1'b0);
      chk("mid_msel_rst", msel, 3'b100);
      @(negedge clk); #1;
      chk("mid_rvalid2", rvalid, 2'b00);
      reset = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
